// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path.
// Holds the voice slot count, MIDI note width, the note code that means
// "no voice", and the state encoding of the allocator's event FSM.
package synth_pkg;

  localparam int NBANKS = 10;
  localparam int IDX_W  = 4;
  localparam int MIDI_W = 7;

  localparam logic [MIDI_W-1:0] MIDI_SILENT = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/voice_table.sv
// Voice slot table: NBANKS entries of {active, note}.
// Ports:
//   clk, rst                 clock, asynchronous active-low clear
//   wr_en/wr_idx/wr_active/wr_note   synchronous write port (allocator COMMIT)
//   scan_idx -> scan_active/scan_note   async read port for the FSM scan
//   rd_idx   -> rd_active/rd_note       async read port for the output stream
//   active_vec               all active bits, for the full flag
module voice_table #(
  parameter int NBANKS = synth_pkg::NBANKS,
  parameter int IDX_W  = synth_pkg::IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic                        wr_active,
  input  logic [synth_pkg::MIDI_W-1:0] wr_note,
  input  logic [IDX_W-1:0]            scan_idx,
  output logic                        scan_active,
  output logic [synth_pkg::MIDI_W-1:0] scan_note,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic                        rd_active,
  output logic [synth_pkg::MIDI_W-1:0] rd_note,
  output logic [NBANKS-1:0]           active_vec
);
  import synth_pkg::*;

  logic [NBANKS-1:0] active_q;
  logic [MIDI_W-1:0] note_q [NBANKS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      for (int k = 0; k < NBANKS; k++) note_q[k] <= MIDI_SILENT;
    end else if (wr_en) begin
      active_q[wr_idx] <= wr_active;
      note_q[wr_idx]   <= wr_note;
    end
  end

  // Reads see the pre-write contents on the edge a write lands.
  assign scan_active = active_q[scan_idx];
  assign scan_note   = note_q[scan_idx];
  assign rd_active   = active_q[rd_idx];
  assign rd_note     = note_q[rd_idx];
  assign active_vec  = active_q;

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: maps MIDI note-on/off events to NBANKS voice slots and
// streams one slot per clk_en period, in the phase bank's round-robin order.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clk_en          sample-rate enable, advances the slot stream
//   i_valid/i_on/i_note   event request (on/off, note number)
//   o_ready         event accepted when i_valid && o_ready
//   o_drop          one-clk pulse: note-on rejected, no free slot
//   o_full          all slots active
//   o_midi/o_slot   note and index of the slot currently presented
module voice_allocator #(
  parameter int NBANKS = synth_pkg::NBANKS,
  parameter int IDX_W  = synth_pkg::IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        i_valid,
  input  logic                        i_on,
  input  logic [synth_pkg::MIDI_W-1:0] i_note,
  output logic                        o_ready,
  output logic                        o_drop,
  output logic                        o_full,
  output logic [synth_pkg::MIDI_W-1:0] o_midi,
  output logic [IDX_W-1:0]            o_slot
);
  import synth_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBANKS - 1);

  fsm_state_t        state;
  logic              on_q;
  logic [MIDI_W-1:0] note_q;
  logic [IDX_W-1:0]  scan_idx, match_idx, free_idx, rd_idx;
  logic              match_found, free_found;

  logic              scan_active, rd_active;
  logic [MIDI_W-1:0] scan_note, rd_note;
  logic [NBANKS-1:0] active_vec;

  logic              hit, vacant, match_nxt, free_nxt;
  logic              wr_en, wr_active;
  logic [IDX_W-1:0]  wr_idx;
  logic [MIDI_W-1:0] wr_note;

  voice_table #(.NBANKS(NBANKS), .IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_active  (wr_active),
    .wr_note    (wr_note),
    .scan_idx   (scan_idx),
    .scan_active(scan_active),
    .scan_note  (scan_note),
    .rd_idx     (rd_idx),
    .rd_active  (rd_active),
    .rd_note    (rd_note),
    .active_vec (active_vec)
  );

  // Scan results including the slot under inspection this cycle; used so the
  // drop decision is ready on the edge that enters COMMIT.
  assign hit       = scan_active && (scan_note == note_q);
  assign vacant    = !scan_active;
  assign match_nxt = match_found || hit;
  assign free_nxt  = free_found || vacant;

  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = match_idx;
    wr_active = 1'b0;
    wr_note   = MIDI_SILENT;
    if (state == COMMIT) begin
      if (on_q) begin
        // Retriggers are ignored; a new note takes the lowest free slot.
        if (!match_found && free_found) begin
          wr_en     = 1'b1;
          wr_idx    = free_idx;
          wr_active = 1'b1;
          wr_note   = note_q;
        end
      end else if (match_found) begin
        wr_en = 1'b1;
      end
    end
  end

  // Event FSM control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      scan_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      o_ready     <= 1'b1;
      o_drop      <= 1'b0;
    end else begin
      o_drop <= 1'b0;
      case (state)
        IDLE: begin
          // A note-0 event is accepted but carries no voice, so it is dropped here.
          if (i_valid && (i_note != MIDI_SILENT)) begin
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            o_ready     <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          match_found <= match_nxt;
          free_found  <= free_nxt;
          if (scan_idx == LAST) begin
            o_drop <= on_q && !match_nxt && !free_nxt;
            state  <= COMMIT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        COMMIT: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Event FSM data: latched event and first-hit slot indices
  always_ff @(posedge clk) begin
    if (state == IDLE && i_valid) begin
      on_q   <= i_on;
      note_q <= i_note;
    end
    if (state == SCAN) begin
      if (hit && !match_found) match_idx <= scan_idx;
      if (vacant && !free_found) free_idx <= scan_idx;
    end
  end

  // Output slot stream and full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx <= '0;
      o_midi <= MIDI_SILENT;
      o_slot <= '0;
      o_full <= 1'b0;
    end else begin
      o_full <= &active_vec;
      if (clk_en) begin
        o_midi <= rd_active ? rd_note : MIDI_SILENT;
        o_slot <= rd_idx;
        rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: event vector table plus hand-written
// reset-mid-scan and clk_en-hold sequences; slot stream checked through a
// scoreboard queue fed by a reference slot table.
module tb_voice_allocator;

  localparam int NB = 10;
  localparam int IW = 4;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       i_valid;
  logic       i_on;
  logic [6:0] i_note;
  logic       o_ready;
  logic       o_drop;
  logic       o_full;
  logic [6:0] o_midi;
  logic [IW-1:0] o_slot;

  voice_allocator #(.NBANKS(NB), .IDX_W(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .i_valid(i_valid),
    .i_on   (i_on),
    .i_note (i_note),
    .o_ready(o_ready),
    .o_drop (o_drop),
    .o_full (o_full),
    .o_midi (o_midi),
    .o_slot (o_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [6:0] midi;
  } sb_t;

  typedef struct {
    logic       rst_before;
    logic       on;
    logic [6:0] note;
    logic       exp_drop;
    logic       exp_full;
    logic       round;
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[$];

  logic       mact [NB];
  logic [6:0] mnote[NB];
  int         m_rd;
  int         en_cnt;
  logic       en_hold;
  logic [6:0] frz_midi;
  logic [IW-1:0] frz_slot;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) begin
      mact[k]  = 1'b0;
      mnote[k] = 7'h00;
    end
    m_rd   = 0;
    en_cnt = 0;
  endtask

  task automatic model_apply(input logic on, input logic [6:0] nt);
    int m;
    int f;
    m = -1;
    f = -1;
    for (int k = 0; k < NB; k++) begin
      if (m < 0 && mact[k] && mnote[k] == nt) m = k;
      if (f < 0 && !mact[k]) f = k;
    end
    if (on) begin
      if (m < 0 && f >= 0) begin
        mact[f]  = 1'b1;
        mnote[f] = nt;
      end
    end else if (m >= 0) begin
      mact[m]  = 1'b0;
      mnote[m] = 7'h00;
    end
  endtask

  // One clock: clk_en on every 4th clk unless held; expected slot pushed at
  // the edge, compared 1 time unit later.
  task automatic step();
    logic en;
    sb_t  e;
    en = !en_hold && (en_cnt == 3);
    clk_en = en;
    @(posedge clk);
    en_cnt = (en_cnt == 3) ? 0 : en_cnt + 1;
    if (en) begin
      exp_q.push_back('{slot: m_rd, midi: (mact[m_rd] ? mnote[m_rd] : 7'h00)});
      m_rd = (m_rd == NB - 1) ? 0 : m_rd + 1;
    end
    #1;
    if (en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: no expected entry for stream output at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("stream_slot", 32'(o_slot), 32'(e.slot));
        check("stream_midi", 32'(o_midi), 32'(e.midi));
      end
    end
    if (en_hold) begin
      check("hold_midi", 32'(o_midi), 32'(frz_midi));
      check("hold_slot", 32'(o_slot), 32'(frz_slot));
    end
  endtask

  task automatic round();
    repeat (4 * NB) step();
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    clk_en  = 1'b0;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_drop",  32'(o_drop),  32'd0);
    check("rst_full",  32'(o_full),  32'd0);
    check("rst_midi",  32'(o_midi),  32'd0);
    check("rst_slot",  32'(o_slot),  32'd0);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic send_event(input logic on, input logic [6:0] nt, input logic exp_drop,
                            input logic poke);
    check("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_on    = on;
    i_note  = nt;
    step();
    i_valid = 1'b0;
    if (nt == 7'h00) begin
      check("ready_null", 32'(o_ready), 32'd1);
      check("drop_null",  32'(o_drop),  32'd0);
    end else begin
      check("ready_scan", 32'(o_ready), 32'd0);
      for (int k = 1; k <= NB; k++) begin
        if (poke && k == 3) begin
          i_valid = 1'b1;
          i_on    = 1'b1;
          i_note  = 7'h11;
        end
        step();
        i_valid = 1'b0;
      end
      check("drop_commit", 32'(o_drop), 32'(exp_drop));
      step();
      model_apply(on, nt);
      check("drop_after", 32'(o_drop),  32'd0);
      check("ready_back", 32'(o_ready), 32'd1);
      step();
    end
  endtask

  initial begin
    rst     = 1'b0;
    clk_en  = 1'b0;
    i_valid = 1'b0;
    i_on    = 1'b0;
    i_note  = 7'h00;
    en_hold = 1'b0;
    frz_midi = 7'h00;
    frz_slot = '0;
    model_clear();

    // rst_before, on, note, exp_drop, exp_full, round
    vecs.push_back('{1'b1, 1'b1, 7'h3C, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 7'h3C, 1'b0, 1'b0, 1'b1});
    for (int n = 0; n < 9; n++)
      vecs.push_back('{(n == 0), 1'b1, 7'(8'h30 + n), 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 7'h39, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 7'h50, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 7'h33, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 7'h50, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 7'h7F, 1'b0, 1'b1, 1'b1});

    do_reset();

    foreach (vecs[v]) begin
      if (vecs[v].rst_before) do_reset();
      send_event(vecs[v].on, vecs[v].note, vecs[v].exp_drop, 1'b0);
      check("full", 32'(o_full), 32'(vecs[v].exp_full));
      if (vecs[v].round) round();
    end

    // Reset three clocks into SCAN with a full table: event aborted, table cleared.
    check("ready_pre_abort", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_on    = 1'b1;
    i_note  = 7'h45;
    step();
    i_valid = 1'b0;
    repeat (3) step();
    check("ready_in_scan", 32'(o_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_midi",  32'(o_midi),  32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_slot",  32'(o_slot),  32'd0);
    check("abort_full",  32'(o_full),  32'd0);
    check("abort_drop",  32'(o_drop),  32'd0);
    clk_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    round();
    check("abort_full_after", 32'(o_full), 32'd0);

    // clk_en held low for 20 clk: stream frozen while the table still updates;
    // a request during SCAN and a note-0 note-on leave the table alone.
    frz_midi = o_midi;
    frz_slot = o_slot;
    en_hold  = 1'b1;
    send_event(1'b1, 7'h22, 1'b0, 1'b1);
    send_event(1'b1, 7'h00, 1'b0, 1'b0);
    repeat (6) step();
    en_hold = 1'b0;
    check("hold_full", 32'(o_full), 32'd0);
    round();

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Upstream feeder for the pipelined phase bank. It accepts MIDI note-on/note-off events, assigns each sounding note to one of NBANKS voice slots, and emits a time-multiplexed 7-bit MIDI stream. On each clk_en period it presents one slot, in the same round-robin order the phase bank walks its accumulators. A silent slot is emitted as note 7'h00, which the phase bank treats as "no voice".

Parameters:
NBANKS, 10, number of voice slots; must equal the phase bank's bank count
IDX_W, 4, width of slot index; ceil(log2(NBANKS))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
clk_en  in  1  sample-rate enable; advances the output slot stream
i_valid  in  1  event request
i_on  in  1  1 = note-on, 0 = note-off; qualified by i_valid
i_note  in  7  MIDI note number; qualified by i_valid
o_ready  out  1  event accepted on clk edge where i_valid && o_ready
o_drop  out  1  one-clk pulse: note-on rejected, all slots busy
o_full  out  1  all NBANKS slots active
o_midi  out  7  note of current slot, 7'h00 if slot inactive
o_slot  out  IDX_W  index of slot currently on o_midi

Behaviour:
- Reset (rst==0, async): slot table cleared (all inactive, notes 0); rd_idx=0; FSM=IDLE; o_ready=1; o_drop=0; o_full=0; o_midi=7'h00; o_slot=0. Reset mid-SCAN/COMMIT aborts the event with no table change.
- Output stream: on each clk edge with clk_en=1: o_midi <= active[rd_idx] ? note[rd_idx] : 7'h00; o_slot <= rd_idx; rd_idx wraps NBANKS-1 -> 0. clk_en=0: o_midi, o_slot, rd_idx hold. Slot k is presented in the clk_en period in which the phase bank's bank index is k (both leave reset together).
- FSM IDLE -> SCAN -> COMMIT -> IDLE; runs on every clk, independent of clk_en.
- IDLE: o_ready=1. On i_valid: latch i_on, i_note; clear scan_idx, match_found, free_found; go to SCAN. If i_note==7'h00, the event is accepted and then discarded: go to IDLE, no table change.
- SCAN: o_ready=0; one slot per clk. Record the first slot with active && note==latched note as match_idx. Record the lowest-index inactive slot as free_idx. Go to COMMIT after scan_idx==NBANKS-1, so SCAN lasts exactly NBANKS cycles.
- COMMIT (1 cycle):
  - note-on with match: no-op (retrigger ignored).
  - note-on, no match, free slot: write note, set active.
  - note-on, no match, no free slot: o_drop=1 for this cycle.
  - note-off with match: clear active, set note to 0.
  - note-off, no match: no-op.
  - Return to IDLE.
- Event-to-table latency: NBANKS+1 clk after acceptance; next event is accepted at earliest NBANKS+2 clk after the previous one.
- A table write takes effect at the next clk_en read of that slot. A write and a read of the same slot on the same edge returns the old value.
- o_full: registered; equals AND of active bits, updated the cycle after COMMIT.
- i_valid outside IDLE is ignored; no queueing.

Decomposition:
- Shared package synth_pkg:
  - NBANKS
  - MIDI_W=7
  - MIDI_SILENT=7'h00
  - FSM state encoding: IDLE, SCAN, COMMIT
- One sub-module: voice_table.
  - Holds NBANKS x {active, note[6:0]}.
  - One synchronous write port (from COMMIT).
  - Two async read ports: scan index and rd_idx.
  - Active-low async clear.
- The FSM and the output stream stay in voice_allocator.

Test Plan:
1. Reset, clk_en every 4th clk, note-on 0x3C -> after NBANKS+1 clk, o_midi=0x3C when o_slot=0 and 0x00 in all other slots; o_full=0.
2. Note-on 0x3C, then 0x40 -> slot0=0x3C, slot1=0x40. Repeat note-on 0x3C -> table unchanged, o_drop stays 0.
3. Ten distinct note-ons 0x30..0x39 -> o_full=1. Eleventh note-on 0x50 -> single-clk o_drop pulse, 0x50 absent from stream.
4. Full table, note-off 0x33 (slot3) -> slot3 emits 0x00, o_full=0. Note-on 0x50 -> lands in slot3. Note-off 0x7F (absent) -> no change.
5. rst=0 asserted 3 clk into SCAN -> immediately o_midi=0, o_ready=1, all slots inactive. Event has no effect.
6. clk_en held 0 for 20 clk while an event is processed -> o_midi/o_slot frozen, table still updated. i_valid pulsed while o_ready=0 -> ignored; note 0x00 note-on -> no table change.
